// File: rtl/pulp_clock_gate_ctrl.sv
// Idle-detect and wake controller for a downstream asynchronous clock gate.
// Runs on the ungated clock and hides the gate's enable-synchronizer latency from requesters.
module pulp_clock_gate_ctrl #(
    parameter int CNT_W    = 16,
    parameter int SYNC_LAT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_en_i,
    input  logic [CNT_W-1:0] cfg_idle_cycles_i,
    input  logic             busy_i,
    input  logic             wake_req_i,
    output logic             clk_en_o,
    output logic             clk_gated_o,
    output logic             wake_ack_o,
    output logic [CNT_W-1:0] gate_events_o
);

    localparam int                WAIT_W    = (SYNC_LAT > 1) ? $clog2(SYNC_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_LAT - 1);

    typedef enum logic [1:0] {
        RUN,
        STOP,
        GATED,
        WAKE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  idle_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic idle_qual;
    logic wait_done;
    logic ack_next;

    // A pending wake request never counts as idle, so it always beats a threshold hit.
    assign idle_qual = cfg_en_i & ~busy_i & ~wake_req_i;
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign ack_next  = wake_req_i & ~wake_ack_o &
                       ((state == RUN) | ((state == WAKE) & wait_done));

    // NOTE: all state and outputs update with non-blocking assignments in one clocked block,
    // so every output is a flop and reset applies synchronously on the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= RUN;
            idle_cnt      <= '0;
            wait_cnt      <= '0;
            clk_en_o      <= 1'b1;
            clk_gated_o   <= 1'b0;
            wake_ack_o    <= 1'b0;
            gate_events_o <= '0;
        end else begin
            wake_ack_o <= ack_next;
            case (state)
                RUN: begin
                    clk_en_o    <= 1'b1;
                    clk_gated_o <= 1'b0;
                    wait_cnt    <= '0;
                    if (!idle_qual) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == cfg_idle_cycles_i) begin
                        idle_cnt <= '0;
                        clk_en_o <= 1'b0;
                        state    <= STOP;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (wake_req_i | ~cfg_en_i | busy_i) begin
                        clk_en_o <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAKE;
                    end else if (wait_done) begin
                        clk_gated_o <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= GATED;
                        if (gate_events_o != '1) begin
                            gate_events_o <= gate_events_o + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                GATED: begin
                    // Activity cannot be observed while stopped; only a request or disable wakes.
                    if (wake_req_i | ~cfg_en_i) begin
                        clk_en_o    <= 1'b1;
                        clk_gated_o <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= WAKE;
                    end
                end
                WAKE: begin
                    if (wait_done) begin
                        idle_cnt <= '0;
                        wait_cnt <= '0;
                        state    <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    clk_en_o    <= 1'b1;
                    clk_gated_o <= 1'b0;
                    idle_cnt    <= '0;
                    wait_cnt    <= '0;
                    state       <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a monitor pops
// one entry after every rising edge and compares it with the registered outputs.
module tb_pulp_clock_gate_ctrl;

    localparam int CNT_W    = 4;
    localparam int SYNC_LAT = 3;

    typedef struct {
        string            tag;
        logic             en;
        logic             gated;
        logic             ack;
        logic [CNT_W-1:0] ev;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             cfg_en_i;
    logic [CNT_W-1:0] cfg_idle_cycles_i;
    logic             busy_i;
    logic             wake_req_i;
    logic             clk_en_o;
    logic             clk_gated_o;
    logic             wake_ack_o;
    logic [CNT_W-1:0] gate_events_o;

    exp_t exp_q[$];
    int   applied = 0;
    int   miscompares = 0;
    logic [CNT_W-1:0] ev_exp;

    pulp_clock_gate_ctrl #(
        .CNT_W   (CNT_W),
        .SYNC_LAT(SYNC_LAT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_idle_cycles_i(cfg_idle_cycles_i),
        .busy_i           (busy_i),
        .wake_req_i       (wake_req_i),
        .clk_en_o         (clk_en_o),
        .clk_gated_o      (clk_gated_o),
        .wake_ack_o       (wake_ack_o),
        .gate_events_o    (gate_events_o)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per rising edge, checked 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                applied++;
                if (clk_en_o !== e.en || clk_gated_o !== e.gated ||
                    wake_ack_o !== e.ack || gate_events_o !== e.ev) begin
                    miscompares++;
                    $display("FAIL %s: got en=%b gated=%b ack=%b ev=%0d, want en=%b gated=%b ack=%b ev=%0d",
                             e.tag, clk_en_o, clk_gated_o, wake_ack_o, gate_events_o,
                             e.en, e.gated, e.ack, e.ev);
                end
            end
        end
    end

    // Called at a negedge with inputs already set; expectation is for the next rising edge.
    task automatic tick(input logic en, input logic gated, input logic ack,
                        input logic [CNT_W-1:0] ev, input string tag);
        exp_t e;
        e.tag   = tag;
        e.en    = en;
        e.gated = gated;
        e.ack   = ack;
        e.ev    = ev;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic en, input logic gated, input logic ack,
                         input logic [CNT_W-1:0] ev, input string tag);
        for (int i = 0; i < n; i++) tick(en, gated, ack, ev, tag);
    endtask

    // Wake from GATED with a held request; requester drops it the cycle after the ack.
    task automatic wake_from_gated(input logic [CNT_W-1:0] ev, input string tag);
        wake_req_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, ev, {tag, "_req_edge"});
        ticks(SYNC_LAT - 1, 1'b1, 1'b0, 1'b0, ev, {tag, "_wake"});
        tick(1'b1, 1'b0, 1'b1, ev, {tag, "_ack"});
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, ev, {tag, "_ack_once"});
        wake_req_i = 1'b0;
    endtask

    initial begin
        rst_i             = 1'b1;
        cfg_en_i          = 1'b1;
        cfg_idle_cycles_i = 4'd4;
        busy_i            = 1'b1;
        wake_req_i        = 1'b0;
        @(negedge clk);

        // Reset held two cycles
        ticks(2, 1'b1, 1'b0, 1'b0, 4'd0, "reset");
        rst_i = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 4'd0, "run_busy");

        // Idle count restarted by a busy pulse after 3 idle cycles
        busy_i = 1'b0;
        ticks(3, 1'b1, 1'b0, 1'b0, 4'd0, "idle_pre");
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd0, "busy_pulse");
        busy_i = 1'b0;
        ticks(4, 1'b1, 1'b0, 1'b0, 4'd0, "idle_count");
        tick(1'b0, 1'b0, 1'b0, 4'd0, "enter_stop");
        ticks(SYNC_LAT - 1, 1'b0, 1'b0, 1'b0, 4'd0, "stop_wait");
        tick(1'b0, 1'b1, 1'b0, 4'd1, "gated");
        busy_i = 1'b1;
        ticks(2, 1'b0, 1'b1, 1'b0, 4'd1, "gated_busy_ignored");

        // Wake from GATED
        wake_from_gated(4'd1, "wake1");

        // Abort in the 2nd STOP cycle via wake request
        busy_i = 1'b0;
        ticks(4, 1'b1, 1'b0, 1'b0, 4'd1, "idle2");
        tick(1'b0, 1'b0, 1'b0, 4'd1, "enter_stop2");
        tick(1'b0, 1'b0, 1'b0, 4'd1, "stop2_first");
        wake_req_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd1, "abort_req");
        ticks(SYNC_LAT - 1, 1'b1, 1'b0, 1'b0, 4'd1, "abort_wake");
        tick(1'b1, 1'b0, 1'b1, 4'd1, "abort_ack");
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd1, "abort_ack_once");

        // Wake request in RUN; still high two cycles after ack is a new request
        tick(1'b1, 1'b0, 1'b1, 4'd1, "run_req_again");
        wake_req_i = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 4'd1, "run_req_drop");

        // cfg_en_i low while GATED wakes without ack
        busy_i = 1'b0;
        ticks(4, 1'b1, 1'b0, 1'b0, 4'd1, "idle3");
        tick(1'b0, 1'b0, 1'b0, 4'd1, "enter_stop3");
        ticks(SYNC_LAT - 1, 1'b0, 1'b0, 1'b0, 4'd1, "stop3_wait");
        tick(1'b0, 1'b1, 1'b0, 4'd2, "gated3");
        cfg_en_i = 1'b0;
        ticks(SYNC_LAT + 1, 1'b1, 1'b0, 1'b0, 4'd2, "cfg_off_wake");
        ticks(3, 1'b1, 1'b0, 1'b0, 4'd2, "cfg_off_run");

        // cfg_en_i falling mid-count clears it; busy aborts STOP
        cfg_en_i = 1'b1;
        ticks(3, 1'b1, 1'b0, 1'b0, 4'd2, "idle4_pre");
        cfg_en_i = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 4'd2, "cfg_drop_run");
        cfg_en_i = 1'b1;
        ticks(4, 1'b1, 1'b0, 1'b0, 4'd2, "idle4");
        tick(1'b0, 1'b0, 1'b0, 4'd2, "enter_stop4");
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd2, "busy_abort");
        ticks(SYNC_LAT, 1'b1, 1'b0, 1'b0, 4'd2, "busy_abort_wake");

        // N=0 gates after the first qualifying cycle
        cfg_idle_cycles_i = 4'd0;
        busy_i = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 4'd2, "n0_stop");
        ticks(SYNC_LAT - 1, 1'b0, 1'b0, 1'b0, 4'd2, "n0_wait");
        tick(1'b0, 1'b1, 1'b0, 4'd3, "n0_gated");
        wake_from_gated(4'd3, "wake_n0");

        // Reset while GATED
        busy_i = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 4'd3, "n0b_stop");
        ticks(SYNC_LAT - 1, 1'b0, 1'b0, 1'b0, 4'd3, "n0b_wait");
        tick(1'b0, 1'b1, 1'b0, 4'd4, "n0b_gated");
        rst_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd0, "reset_in_gated");
        rst_i  = 1'b0;
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd0, "after_reset");

        // Saturation over 17 gate/wake loops
        ev_exp = '0;
        for (int k = 0; k < 17; k++) begin
            busy_i = 1'b0;
            tick(1'b0, 1'b0, 1'b0, ev_exp, "sat_stop");
            ticks(SYNC_LAT - 1, 1'b0, 1'b0, 1'b0, ev_exp, "sat_wait");
            if (ev_exp != 4'd15) ev_exp = ev_exp + 4'd1;
            tick(1'b0, 1'b1, 1'b0, ev_exp, "sat_gated");
            wake_from_gated(ev_exp, "sat_wake");
        end
        busy_i = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 4'd15, "sat_final");

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
